// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a length-prefixed big-endian byte stream into
// consecutive word writes from address 0, holding the CPU in reset meanwhile.
module imem_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wd,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            word_count,
    output logic                  err_op,
    output logic                  err_len
);

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_BYTE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [7:0]            word_idx_q, word_idx_d;
    logic [7:0]            len_q, len_d;
    logic [23:0]           shift_q, shift_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wd_q, imem_wd_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [7:0]            word_count_q, word_count_d;
    logic                  err_op_q, err_op_d;
    logic                  err_len_q, err_len_d;

    logic                  accept;
    logic [31:0]           word_full;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            6'b000000, 6'b100011, 6'b101011,
            6'b000100, 6'b001000, 6'b000010: op_supported = 1'b1;
            default:                         op_supported = 1'b0;
        endcase
    endfunction

    assign accept    = rx_valid && rx_ready_q;
    assign word_full = {shift_q, rx_data};

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        word_idx_d   = word_idx_q;
        len_d        = len_q;
        shift_d      = shift_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wd_d    = imem_wd_q;
        word_count_d = word_count_q;
        err_op_d     = err_op_q;
        err_len_d    = err_len_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LEN;
                    err_op_d     = 1'b0;
                    err_len_d    = 1'b0;
                    word_count_d = 8'd0;
                    word_idx_d   = 8'd0;
                    imem_addr_d  = '0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    len_d      = rx_data;
                    byte_idx_d = 2'd0;
                    if ({24'd0, rx_data} > DEPTH) begin
                        err_len_d = 1'b1;
                    end
                    state_d = (rx_data == 8'd0) ? S_DONE : S_BYTE;
                end
            end
            S_BYTE: begin
                if (accept) begin
                    shift_d    = word_full[23:0];
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                        // Write strobe, address and data are registered here so they
                        // are all valid together for the whole WRITE cycle.
                        if ({24'd0, word_idx_q} < DEPTH) begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = ADDR_WIDTH'(word_idx_q);
                            imem_wd_d    = word_full;
                            word_count_d = word_count_q + 8'd1;
                            if (!op_supported(word_full[31:26])) begin
                                err_op_d = 1'b1;
                            end
                        end
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 8'd1;
                byte_idx_d = 2'd0;
                state_d    = (word_idx_q + 8'd1 == len_q) ? S_DONE : S_BYTE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered copies of what the next state implies.
        rx_ready_d = (state_d == S_LEN) || (state_d == S_BYTE);
        busy_d     = (state_d != S_IDLE);
        cpu_hold_d = busy_d;
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= 2'd0;
            word_idx_q   <= 8'd0;
            len_q        <= 8'd0;
            shift_q      <= 24'd0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wd_q    <= 32'd0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            word_count_q <= 8'd0;
            err_op_q     <= 1'b0;
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            word_idx_q   <= word_idx_d;
            len_q        <= len_d;
            shift_q      <= shift_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wd_q    <= imem_wd_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            word_count_q <= word_count_d;
            err_op_q     <= err_op_d;
            err_len_q    <= err_len_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wd    = imem_wd_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_count = word_count_q;
    assign err_op     = err_op_q;
    assign err_len    = err_len_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a 64-word and a 4-word instance share one byte stream;
// observed writes and flags are compared against a frame-level reference model.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;

    logic        rx_ready_a, we_a, hold_a, busy_a, done_a, err_op_a, err_len_a;
    logic [5:0]  addr_a;
    logic [31:0] wd_a;
    logic [7:0]  wc_a;
    logic        rx_ready_b, we_b, hold_b, busy_b, done_b, err_op_b, err_len_b;
    logic [1:0]  addr_b;
    logic [31:0] wd_b;
    logic [7:0]  wc_b;

    imem_loader #(.ADDR_WIDTH(6)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready_a), .imem_we(we_a), .imem_addr(addr_a), .imem_wd(wd_a),
        .cpu_hold(hold_a), .busy(busy_a), .done(done_a), .word_count(wc_a),
        .err_op(err_op_a), .err_len(err_len_a)
    );

    imem_loader #(.ADDR_WIDTH(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wd(wd_b),
        .cpu_hold(hold_b), .busy(busy_b), .done(done_b), .word_count(wc_b),
        .err_op(err_op_b), .err_len(err_len_b)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    int          wa_addr[$];
    logic [31:0] wa_data[$];
    int          wa_cyc[$];
    int          wb_addr[$];
    logic [31:0] wb_data[$];

    logic [31:0] words[256];
    logic [5:0]  ops[6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we_a === 1'b1) begin
            wa_addr.push_back(int'(addr_a));
            wa_data.push_back(wd_a);
            wa_cyc.push_back(cyc);
        end
        if (we_b === 1'b1) begin
            wb_addr.push_back(int'(addr_b));
            wb_data.push_back(wd_b);
        end
    end

    // Reference model: what a whole frame should leave behind for a given depth.
    function automatic int exp_writes(input int n, input int depth);
        return (n < depth) ? n : depth;
    endfunction

    function automatic bit op_ok(input logic [5:0] op);
        foreach (ops[i]) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_err_op(input int n, input int depth);
        for (int i = 0; i < exp_writes(n, depth); i++)
            if (!op_ok(words[i][31:26])) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_mon();
        wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
        wb_addr.delete(); wb_data.delete();
    endtask

    task automatic start_load();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit toggle);
        int w;
        rx_data  = b;
        rx_valid = 1'b1;
        w = 0;
        while (rx_ready_a !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) begin
            total_cnt++;
            $display("FAIL byte_handshake: rx_ready=%b after %0d cycles, required 1", rx_ready_a, w);
        end
        @(negedge clk);
        if (toggle) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_words(input int n, input bit toggle);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], toggle);
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit toggle);
        logic [31:0] nn;
        nn = n;
        send_byte(nn[7:0], toggle);
        send_words(n, toggle);
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (done_a !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) begin
            total_cnt++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done_a, w);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({rx_ready_a, we_a, addr_a, wd_a, hold_a, busy_a, done_a, wc_a, err_op_a, err_len_a} !== '0)
            $display("FAIL reset_a: rdy=%b we=%b addr=%0d wd=%h hold=%b busy=%b done=%b wc=%0d eop=%b elen=%b, required all 0",
                     rx_ready_a, we_a, addr_a, wd_a, hold_a, busy_a, done_a, wc_a, err_op_a, err_len_a);
        else pass_cnt++;
        total_cnt++;
        if ({rx_ready_b, we_b, addr_b, wd_b, hold_b, busy_b, done_b, wc_b, err_op_b, err_len_b} !== '0)
            $display("FAIL reset_b: outputs not all zero, busy=%b wc=%0d", busy_b, wc_b);
        else pass_cnt++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (busy_a !== 1'b0 || rx_ready_a !== 1'b0) $display("FAIL idle_no_start: busy=%b rdy=%b, required 0 0", busy_a, rx_ready_a);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int d;
        clear_mon();
        words[0] = 32'h20080005;
        words[1] = 32'h8C090000;
        start_load();
        total_cnt++;
        if (busy_a !== 1'b1 || hold_a !== 1'b1 || rx_ready_a !== 1'b1)
            $display("FAIL start_edge: busy=%b hold=%b rdy=%b, required 1 1 1", busy_a, hold_a, rx_ready_a);
        else pass_cnt++;
        send_frame(2, 1'b0);
        wait_done();
        d = cyc;
        total_cnt++;
        if (wa_addr.size() != 2) $display("FAIL basic_nwrites: got %0d, required 2", wa_addr.size());
        else pass_cnt++;
        for (int i = 0; i < wa_addr.size() && i < 2; i++) begin
            total_cnt++;
            if (wa_addr[i] != i || wa_data[i] !== words[i])
                $display("FAIL basic_write%0d: addr=%0d data=%h, required addr=%0d data=%h", i, wa_addr[i], wa_data[i], i, words[i]);
            else pass_cnt++;
        end
        if (wa_cyc.size() == 2) begin
            total_cnt++;
            if (wa_cyc[1] - wa_cyc[0] != 5) $display("FAIL basic_spacing: got %0d cycles, required 5", wa_cyc[1] - wa_cyc[0]);
            else pass_cnt++;
            total_cnt++;
            if (d != wa_cyc[1] + 1) $display("FAIL basic_done_time: done at %0d, required %0d", d, wa_cyc[1] + 1);
            else pass_cnt++;
        end
        total_cnt++;
        if (wc_a !== 8'd2 || err_op_a !== 1'b0 || err_len_a !== 1'b0 || hold_a !== 1'b1)
            $display("FAIL basic_status: wc=%0d eop=%b elen=%b hold=%b, required 2 0 0 1", wc_a, err_op_a, err_len_a, hold_a);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (hold_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || wc_a !== 8'd2)
            $display("FAIL basic_after_done: hold=%b busy=%b done=%b wc=%0d, required 0 0 0 2", hold_a, busy_a, done_a, wc_a);
        else pass_cnt++;
    endtask

    task automatic test_bad_op();
        clear_mon();
        words[0] = 32'hFC000000;
        start_load();
        send_frame(1, 1'b0);
        wait_done();
        total_cnt++;
        if (wa_addr.size() != 1 || wa_data[0] !== 32'hFC000000 || wa_addr[0] != 0)
            $display("FAIL badop_write: nwrites=%0d, required one write of fc000000 at 0", wa_addr.size());
        else pass_cnt++;
        total_cnt++;
        if (err_op_a !== 1'b1) $display("FAIL badop_flag: err_op=%b, required 1", err_op_a);
        else pass_cnt++;
        @(negedge clk);
        start_load();
        total_cnt++;
        if (err_op_a !== 1'b0) $display("FAIL badop_clear: err_op=%b after start, required 0", err_op_a);
        else pass_cnt++;
        words[0] = 32'h00000020;
        send_frame(1, 1'b0);
        wait_done();
        total_cnt++;
        if (err_op_a !== 1'b0 || wc_a !== 8'd1) $display("FAIL badop_reload: err_op=%b wc=%0d, required 0 1", err_op_a, wc_a);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        clear_mon();
        start_load();
        send_byte(8'd0, 1'b0);
        rx_valid = 1'b0;
        total_cnt++;
        if (done_a !== 1'b1 || wc_a !== 8'd0) $display("FAIL zero_done: done=%b wc=%0d, required 1 0", done_a, wc_a);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (wa_addr.size() != 0 || busy_a !== 1'b0 || done_a !== 1'b0)
            $display("FAIL zero_nowrite: nwrites=%0d busy=%b done=%b, required 0 0 0", wa_addr.size(), busy_a, done_a);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        clear_mon();
        for (int i = 0; i < 5; i++) words[i] = {ops[$urandom_range(0, 5)], 26'($urandom)};
        start_load();
        send_byte(8'd5, 1'b0);
        total_cnt++;
        if (err_len_b !== 1'b1 || err_len_a !== 1'b0)
            $display("FAIL ovf_errlen: small=%b large=%b, required 1 0", err_len_b, err_len_a);
        else pass_cnt++;
        send_words(5, 1'b0);
        wait_done();
        total_cnt++;
        if (done_b !== 1'b1) $display("FAIL ovf_done: done=%b, required 1", done_b);
        else pass_cnt++;
        total_cnt++;
        if (wb_addr.size() != 4 || wc_b !== 8'd4) $display("FAIL ovf_count: nwrites=%0d wc=%0d, required 4 4", wb_addr.size(), wc_b);
        else pass_cnt++;
        for (int i = 0; i < wb_addr.size() && i < 4; i++) begin
            total_cnt++;
            if (wb_addr[i] != i || wb_data[i] !== words[i])
                $display("FAIL ovf_write%0d: addr=%0d data=%h, required addr=%0d data=%h", i, wb_addr[i], wb_data[i], i, words[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (wa_addr.size() != 5 || wc_a !== 8'd5) $display("FAIL ovf_large: nwrites=%0d wc=%0d, required 5 5", wa_addr.size(), wc_a);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_toggle_start();
        clear_mon();
        start_load();
        send_byte(8'd1, 1'b1);
        send_byte(8'h00, 1'b1);
        start = 1'b1;
        send_byte(8'h00, 1'b1);
        start = 1'b0;
        send_byte(8'h00, 1'b1);
        send_byte(8'h20, 1'b1);
        wait_done();
        total_cnt++;
        if (wa_addr.size() != 1 || wa_addr[0] != 0 || wa_data[0] !== 32'h00000020)
            $display("FAIL toggle_write: nwrites=%0d, required one write of 00000020 at 0", wa_addr.size());
        else pass_cnt++;
        total_cnt++;
        if (wc_a !== 8'd1 || err_op_a !== 1'b0) $display("FAIL toggle_status: wc=%0d eop=%b, required 1 0", wc_a, err_op_a);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        clear_mon();
        start_load();
        send_byte(8'd3, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        rx_valid = 1'b0;
        total_cnt++;
        if (busy_a !== 1'b1) $display("FAIL midrst_pre: busy=%b, required 1", busy_a);
        else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({rx_ready_a, we_a, addr_a, wd_a, hold_a, busy_a, done_a, wc_a, err_op_a, err_len_a} !== '0)
            $display("FAIL midrst_async: rdy=%b hold=%b busy=%b wc=%0d, required all 0", rx_ready_a, hold_a, busy_a, wc_a);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        words[0] = 32'h08000004;
        start_load();
        send_frame(1, 1'b0);
        wait_done();
        total_cnt++;
        if (wa_addr.size() != 1 || wa_addr[0] != 0 || wa_data[0] !== 32'h08000004 || wc_a !== 8'd1)
            $display("FAIL midrst_reload: nwrites=%0d wc=%0d, required one write of 08000004 at 0", wa_addr.size(), wc_a);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_random();
        int  n;
        bit  tog;
        for (int it = 0; it < 8; it++) begin
            n   = $urandom_range(0, 7);
            tog = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++)
                words[i] = ($urandom_range(0, 9) < 7) ? {ops[$urandom_range(0, 5)], 26'($urandom)} : $urandom;
            clear_mon();
            start_load();
            send_frame(n, tog);
            wait_done();
            total_cnt++;
            if (wa_addr.size() != exp_writes(n, 64) || wb_addr.size() != exp_writes(n, 4))
                $display("FAIL rand%0d_nwrites: got %0d/%0d, required %0d/%0d", it, wa_addr.size(), wb_addr.size(), exp_writes(n, 64), exp_writes(n, 4));
            else pass_cnt++;
            for (int i = 0; i < wa_addr.size() && i < n; i++) begin
                total_cnt++;
                if (wa_addr[i] != i || wa_data[i] !== words[i])
                    $display("FAIL rand%0d_write%0d: addr=%0d data=%h, required addr=%0d data=%h", it, i, wa_addr[i], wa_data[i], i, words[i]);
                else pass_cnt++;
            end
            for (int i = 0; i < wb_addr.size() && i < 4; i++) begin
                total_cnt++;
                if (wb_addr[i] != i || wb_data[i] !== words[i])
                    $display("FAIL rand%0d_small%0d: addr=%0d data=%h, required addr=%0d data=%h", it, i, wb_addr[i], wb_data[i], i, words[i]);
                else pass_cnt++;
            end
            total_cnt++;
            if (int'(wc_a) != exp_writes(n, 64) || err_op_a !== exp_err_op(n, 64) || err_len_a !== 1'b0)
                $display("FAIL rand%0d_flags_a: wc=%0d eop=%b elen=%b, required %0d %b 0", it, wc_a, err_op_a, err_len_a, exp_writes(n, 64), exp_err_op(n, 64));
            else pass_cnt++;
            total_cnt++;
            if (int'(wc_b) != exp_writes(n, 4) || err_op_b !== exp_err_op(n, 4) || err_len_b !== (n > 4))
                $display("FAIL rand%0d_flags_b: wc=%0d eop=%b elen=%b, required %0d %b %b", it, wc_b, err_op_b, err_len_b, exp_writes(n, 4), exp_err_op(n, 4), n > 4);
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_op();
        test_zero_len();
        test_overflow();
        test_toggle_start();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
